// File: rtl/ecc_pkg.sv
// ecc_pkg -- shared definitions for the ECC scalar-multiplication datapath.
//   state_e      : sequencer states of ecc_scalar_ctrl
//   OP_DBL/ADD   : encoding of o_op_sel towards the point unit
//   SIZE_DEFAULT : default coordinate width on point-unit and result buses
package ecc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_BIT      = 3'd1,
    ST_DBL_REQ  = 3'd2,
    ST_DBL_WAIT = 3'd3,
    ST_ADD_REQ  = 3'd4,
    ST_ADD_WAIT = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

  localparam logic OP_DBL = 1'b0;
  localparam logic OP_ADD = 1'b1;

  localparam int SIZE_DEFAULT = 32;

endpackage

// File: rtl/ecc_scalar_ctrl.sv
// ecc_scalar_ctrl -- left-to-right double-and-add sequencer computing kP.
// Ports:
//   i_clk, i_rst_n            clock (rising edge), async active-low reset
//   i_start, a, prime, Px, Py, k
//                             start request and operands, latched on accept
//   o_op_valid, o_op_sel      one-cycle request to the point unit (0=DBL, 1=ADD)
//   o_op_x1/y1, o_op_x2/y2    operands Q and P presented to the point unit
//   o_a, o_prime              latched curve parameters
//   i_op_done, i_res_x/y/inf  result handshake from the point unit
//   kPx, kPy, o_inf           final result, held until the next completion
//   o_busy, o_done            activity flag and one-cycle completion pulse
module ecc_scalar_ctrl
  import ecc_pkg::*;
#(
  parameter int K_WIDTH = 4,
  parameter int P_WIDTH = 4,
  parameter int SIZE    = SIZE_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [P_WIDTH-1:0] a,
  input  logic [P_WIDTH-1:0] prime,
  input  logic [P_WIDTH-1:0] Px,
  input  logic [P_WIDTH-1:0] Py,
  input  logic [K_WIDTH-1:0] k,
  output logic               o_op_valid,
  output logic               o_op_sel,
  output logic [SIZE-1:0]    o_op_x1,
  output logic [SIZE-1:0]    o_op_y1,
  output logic [SIZE-1:0]    o_op_x2,
  output logic [SIZE-1:0]    o_op_y2,
  output logic [SIZE-1:0]    o_a,
  output logic [SIZE-1:0]    o_prime,
  input  logic               i_op_done,
  input  logic [SIZE-1:0]    i_res_x,
  input  logic [SIZE-1:0]    i_res_y,
  input  logic               i_res_inf,
  output logic [SIZE-1:0]    kPx,
  output logic [SIZE-1:0]    kPy,
  output logic               o_inf,
  output logic               o_busy,
  output logic               o_done
);

  localparam int IDX_W = (K_WIDTH > 1) ? $clog2(K_WIDTH) : 1;

  state_e             state_q, state_d;
  logic [K_WIDTH-1:0] k_q, k_d;
  logic [SIZE-1:0]    a_q, a_d, prime_q, prime_d;
  logic [SIZE-1:0]    px_q, px_d, py_q, py_d;
  logic [SIZE-1:0]    qx_q, qx_d, qy_q, qy_d;
  logic [SIZE-1:0]    kpx_q, kpx_d, kpy_q, kpy_d;
  logic               q_inf_q, q_inf_d;
  logic               inf_q, inf_d;
  logic               done_q, done_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               cur_bit, last_bit;

  assign cur_bit  = k_q[idx_q];
  assign last_bit = (idx_q == '0);

  // ---------------- state register ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (i_start) state_d = ST_BIT;
      // While Q is still infinity no doubling is needed; the bit is absorbed here.
      ST_BIT:      if (q_inf_q) state_d = last_bit ? ST_DONE : ST_BIT;
                   else         state_d = ST_DBL_REQ;
      ST_DBL_REQ:  state_d = ST_DBL_WAIT;
      ST_DBL_WAIT: if (i_op_done) begin
                     if (cur_bit && !i_res_inf) state_d = ST_ADD_REQ;
                     else                       state_d = last_bit ? ST_DONE : ST_BIT;
                   end
      ST_ADD_REQ:  state_d = ST_ADD_WAIT;
      ST_ADD_WAIT: if (i_op_done) state_d = last_bit ? ST_DONE : ST_BIT;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      k_q     <= '0;
      a_q     <= '0;
      prime_q <= '0;
      px_q    <= '0;
      py_q    <= '0;
      qx_q    <= '0;
      qy_q    <= '0;
      q_inf_q <= 1'b1;
      idx_q   <= '0;
      kpx_q   <= '0;
      kpy_q   <= '0;
      inf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      k_q     <= k_d;
      a_q     <= a_d;
      prime_q <= prime_d;
      px_q    <= px_d;
      py_q    <= py_d;
      qx_q    <= qx_d;
      qy_q    <= qy_d;
      q_inf_q <= q_inf_d;
      idx_q   <= idx_d;
      kpx_q   <= kpx_d;
      kpy_q   <= kpy_d;
      inf_q   <= inf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    k_d     = k_q;
    a_d     = a_q;
    prime_d = prime_q;
    px_d    = px_q;
    py_d    = py_q;
    qx_d    = qx_q;
    qy_d    = qy_q;
    q_inf_d = q_inf_q;
    idx_d   = idx_q;
    kpx_d   = kpx_q;
    kpy_d   = kpy_q;
    inf_d   = inf_q;
    done_d  = 1'b0;

    // Every return to BIT from a working state is a step to the next key bit.
    if (state_q != ST_IDLE && state_d == ST_BIT) idx_d = idx_q - IDX_W'(1);

    case (state_q)
      ST_IDLE: if (i_start) begin
        k_d     = k;
        a_d     = SIZE'(a);
        prime_d = SIZE'(prime);
        px_d    = SIZE'(Px);
        py_d    = SIZE'(Py);
        qx_d    = '0;
        qy_d    = '0;
        q_inf_d = 1'b1;
        idx_d   = IDX_W'(K_WIDTH - 1);
      end
      ST_BIT: if (q_inf_q && cur_bit) begin
        qx_d    = px_q;
        qy_d    = py_q;
        q_inf_d = 1'b0;
      end
      ST_DBL_WAIT: if (i_op_done) begin
        // Doubling collapsed to infinity on a set bit: O + P = P, no ADD needed.
        if (cur_bit && i_res_inf) begin
          qx_d    = px_q;
          qy_d    = py_q;
          q_inf_d = 1'b0;
        end else begin
          qx_d    = i_res_x;
          qy_d    = i_res_y;
          q_inf_d = i_res_inf;
        end
      end
      ST_ADD_WAIT: if (i_op_done) begin
        qx_d    = i_res_x;
        qy_d    = i_res_y;
        q_inf_d = i_res_inf;
      end
      ST_DONE: begin
        kpx_d  = q_inf_q ? '0 : qx_q;
        kpy_d  = q_inf_q ? '0 : qy_q;
        inf_d  = q_inf_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    o_op_valid = 1'b0;
    o_op_sel   = OP_DBL;
    o_busy     = (state_q != ST_IDLE);
    case (state_q)
      ST_DBL_REQ: begin o_op_valid = 1'b1; o_op_sel = OP_DBL; end
      ST_ADD_REQ: begin o_op_valid = 1'b1; o_op_sel = OP_ADD; end
      ST_ADD_WAIT: o_op_sel = OP_ADD;
      default: ;
    endcase
  end

  // Q only changes on the done edge, so operands stay stable REQ..done.
  assign o_op_x1 = qx_q;
  assign o_op_y1 = qy_q;
  assign o_op_x2 = px_q;
  assign o_op_y2 = py_q;
  assign o_a     = a_q;
  assign o_prime = prime_q;
  assign kPx     = kpx_q;
  assign kPy     = kpy_q;
  assign o_inf   = inf_q;
  assign o_done  = done_q;

endmodule
